// File: rtl/jtkcpu_intarb_if.sv
// ----------------------------------------------------------------------------
// jtkcpu_intarb_if : pin, CC and microcode handshake bundle for the arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface jtkcpu_intarb_if;
  logic        cen;
  logic        nmi_n;
  logic        firq_n;
  logic        irq_n;
  logic        halt_n;
  logic [7:0]  cc;
  logic        arm_nmi;
  logic        fetch;
  logic        int_ack;
  logic        nmi;
  logic        firq;
  logic        irq;
  logic [15:0] int_vec;
  logic        set_i;
  logic        set_f;
  logic        halted;

  modport master (
    output cen, nmi_n, firq_n, irq_n, halt_n, cc, arm_nmi, fetch, int_ack,
    input  nmi, firq, irq, int_vec, set_i, set_f, halted
  );

  modport slave (
    input  cen, nmi_n, firq_n, irq_n, halt_n, cc, arm_nmi, fetch, int_ack,
    output nmi, firq, irq, int_vec, set_i, set_f, halted
  );
endinterface

`default_nettype wire

// File: rtl/jtkcpu_intarb.sv
// ----------------------------------------------------------------------------
// jtkcpu_intarb : KCPU interrupt/halt arbiter, one-hot request at boundaries
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtkcpu_intarb #(
  parameter logic NMI_ARM = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  jtkcpu_intarb_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;
  localparam logic [1:0] ST_HALTED  = 2'd3;

  // bit 0 is the first synchroniser stage, bit 1 the usable one
  logic [1:0]  r_nmi_sync, r_firq_sync, r_irq_sync, r_halt_sync;
  logic        r_nmi_prev, r_nmi_pend, r_nmi_armed;
  logic [1:0]  r_state;
  logic        r_nmi, r_firq, r_irq, r_set_i, r_set_f, r_halted;
  logic [15:0] r_vec;

  logic w_nmi_edge, w_firq_c, w_irq_c, w_halt, w_any;
  logic w_unused_cc;

  assign w_nmi_edge  = r_nmi_prev & ~r_nmi_sync[1];
  assign w_firq_c    = ~r_firq_sync[1] & ~bus.cc[6];
  assign w_irq_c     = ~r_irq_sync[1]  & ~bus.cc[4];
  assign w_halt      = ~r_halt_sync[1];
  assign w_any       = r_nmi_pend | w_firq_c | w_irq_c;
  assign w_unused_cc = ^{bus.cc[7], bus.cc[5], bus.cc[3:0]};

  assign bus.nmi     = r_nmi;
  assign bus.firq    = r_firq;
  assign bus.irq     = r_irq;
  assign bus.int_vec = r_vec;
  assign bus.set_i   = r_set_i;
  assign bus.set_f   = r_set_f;
  assign bus.halted  = r_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nmi_sync  <= 2'b11;
      r_firq_sync <= 2'b11;
      r_irq_sync  <= 2'b11;
      r_halt_sync <= 2'b11;
      r_nmi_prev  <= 1'b1;
      r_nmi_pend  <= 1'b0;
      r_nmi_armed <= ~NMI_ARM;
    end else if (bus.cen) begin
      r_nmi_sync  <= {r_nmi_sync[0],  bus.nmi_n};
      r_firq_sync <= {r_firq_sync[0], bus.firq_n};
      r_irq_sync  <= {r_irq_sync[0],  bus.irq_n};
      r_halt_sync <= {r_halt_sync[0], bus.halt_n};
      r_nmi_prev  <= r_nmi_sync[1];
      if (bus.arm_nmi) r_nmi_armed <= 1'b1;
      // a fresh edge wins over the clear from a completed NMI service
      if (w_nmi_edge && r_nmi_armed)
        r_nmi_pend <= 1'b1;
      else if (r_state == ST_SERVICE && r_nmi)
        r_nmi_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_nmi    <= 1'b0;
      r_firq   <= 1'b0;
      r_irq    <= 1'b0;
      r_vec    <= 16'h0000;
      r_set_i  <= 1'b0;
      r_set_f  <= 1'b0;
      r_halted <= 1'b0;
    end else if (bus.cen) begin
      r_set_i <= 1'b0;
      r_set_f <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.fetch) begin
            if (w_halt) begin
              r_state  <= ST_HALTED;
              r_halted <= 1'b1;
            end else if (w_any) begin
              r_state <= ST_REQ;
              if (r_nmi_pend) begin
                r_nmi <= 1'b1;
                r_vec <= 16'hFFFC;
              end else if (w_firq_c) begin
                r_firq <= 1'b1;
                r_vec  <= 16'hFFF6;
              end else begin
                r_irq <= 1'b1;
                r_vec <= 16'hFFF8;
              end
            end
          end
        end
        ST_REQ: begin
          if (bus.int_ack) begin
            r_state <= ST_SERVICE;
            r_set_i <= 1'b1;
            r_set_f <= r_nmi | r_firq;
          end
        end
        ST_SERVICE: begin
          r_state <= ST_IDLE;
          r_nmi   <= 1'b0;
          r_firq  <= 1'b0;
          r_irq   <= 1'b0;
          r_vec   <= 16'h0000;
        end
        ST_HALTED: begin
          if (!w_halt) begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtkcpu_intarb.sv
// ----------------------------------------------------------------------------
// tb_jtkcpu_intarb : vector table with scoreboard queue for jtkcpu_intarb
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_jtkcpu_intarb;

  typedef struct {
    logic        cen;
    logic [3:0]  pins;   // {nmi_n, firq_n, irq_n, halt_n}
    logic [7:0]  cc;
    logic [2:0]  ctl;    // {arm_nmi, fetch, int_ack}
    logic [21:0] exp;    // {nmi, firq, irq, int_vec, set_i, set_f, halted}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  vec_t        vecs[$];
  logic [21:0] sb[$];

  jtkcpu_intarb_if bus();

  jtkcpu_intarb #(.NMI_ARM(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic add(input logic cen, input logic [3:0] pins, input logic [7:0] cc,
                     input logic [2:0] ctl, input logic [2:0] req, input logic [15:0] v,
                     input logic [2:0] st);
    vec_t t;
    t.cen  = cen;
    t.pins = pins;
    t.cc   = cc;
    t.ctl  = ctl;
    t.exp  = {req, v, st};
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    bus.cen     = t.cen;
    {bus.nmi_n, bus.firq_n, bus.irq_n, bus.halt_n} = t.pins;
    bus.cc      = t.cc;
    {bus.arm_nmi, bus.fetch, bus.int_ack} = t.ctl;
    sb.push_back(t.exp);
  endtask

  task automatic check(input string name);
    logic [21:0] act, exp;
    act = {bus.nmi, bus.firq, bus.irq, bus.int_vec, bus.set_i, bus.set_f, bus.halted};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
      end
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i));
    end
  endtask

  initial begin
    // NMI pulse before arming, then armed NMI grant and service
    add(1, 4'b1111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);  // 0
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1111, 8'h50, 3'b010, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1111, 8'h50, 3'b010, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1111, 8'h50, 3'b100, 3'b000, 16'h0000, 3'b000);  // 5 arm
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b0111, 8'h50, 3'b010, 3'b100, 16'hFFFC, 3'b000);
    add(1, 4'b0111, 8'h50, 3'b001, 3'b100, 16'hFFFC, 3'b110);  // 10
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1111, 8'h50, 3'b010, 3'b000, 16'h0000, 3'b000);
    // FIRQ beats IRQ
    add(1, 4'b1001, 8'h00, 3'b010, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1001, 8'h00, 3'b010, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1001, 8'h00, 3'b010, 3'b010, 16'hFFF6, 3'b000);  // 15
    add(1, 4'b1001, 8'h00, 3'b001, 3'b010, 16'hFFF6, 3'b110);
    add(1, 4'b1111, 8'h00, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1111, 8'h00, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1111, 8'h00, 3'b000, 3'b000, 16'h0000, 3'b000);
    // IRQ masked, then unmasked; committed request; NMI edge during REQ
    add(1, 4'b1101, 8'h10, 3'b010, 3'b000, 16'h0000, 3'b000);  // 20
    add(1, 4'b1101, 8'h10, 3'b010, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1101, 8'h10, 3'b010, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1101, 8'h10, 3'b010, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1101, 8'h00, 3'b010, 3'b001, 16'hFFF8, 3'b000);
    add(1, 4'b1111, 8'h10, 3'b000, 3'b001, 16'hFFF8, 3'b000);  // 25
    add(1, 4'b1111, 8'h10, 3'b010, 3'b001, 16'hFFF8, 3'b000);
    add(1, 4'b0111, 8'h10, 3'b000, 3'b001, 16'hFFF8, 3'b000);
    add(1, 4'b0111, 8'h10, 3'b000, 3'b001, 16'hFFF8, 3'b000);
    add(1, 4'b0111, 8'h10, 3'b000, 3'b001, 16'hFFF8, 3'b000);
    add(1, 4'b0111, 8'h10, 3'b001, 3'b001, 16'hFFF8, 3'b100);  // 30
    add(1, 4'b0111, 8'h10, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b0111, 8'h10, 3'b010, 3'b100, 16'hFFFC, 3'b000);
    add(1, 4'b0111, 8'h10, 3'b001, 3'b100, 16'hFFFC, 3'b110);
    add(1, 4'b1111, 8'h10, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1111, 8'h10, 3'b001, 3'b000, 16'h0000, 3'b000);  // 35 stray ack
    // halt wins over IRQ, then IRQ after release
    add(1, 4'b1100, 8'h00, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1100, 8'h00, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1100, 8'h00, 3'b010, 3'b000, 16'h0000, 3'b001);
    add(1, 4'b1101, 8'h00, 3'b010, 3'b000, 16'h0000, 3'b001);
    add(1, 4'b1101, 8'h00, 3'b010, 3'b000, 16'h0000, 3'b001);  // 40
    add(1, 4'b1101, 8'h00, 3'b010, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1101, 8'h00, 3'b010, 3'b001, 16'hFFF8, 3'b000);
    add(1, 4'b1101, 8'h00, 3'b001, 3'b001, 16'hFFF8, 3'b100);
    add(1, 4'b1111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    // NMI grant held in REQ for the async reset
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);  // 45
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b0111, 8'h50, 3'b010, 3'b100, 16'hFFFC, 3'b000);
    // after reset NMI is disarmed again
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);  // 50
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b0111, 8'h50, 3'b010, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1111, 8'h50, 3'b010, 3'b000, 16'h0000, 3'b000);
    // cen=0 with everything active, including arm_nmi
    for (int k = 0; k < 5; k++)
      add(0, 4'b0000, 8'h00, 3'b111, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b1111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);  // 59
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b0111, 8'h50, 3'b000, 3'b000, 16'h0000, 3'b000);
    add(1, 4'b0111, 8'h50, 3'b010, 3'b000, 16'h0000, 3'b000);  // 63

    bus.cen = 1'b1; bus.nmi_n = 1'b1; bus.firq_n = 1'b1; bus.irq_n = 1'b1;
    bus.halt_n = 1'b1; bus.cc = 8'h50; bus.arm_nmi = 1'b0; bus.fetch = 1'b0;
    bus.int_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(22'h0);
    check("reset_state");
    #4 rst = 1'b0;
    @(posedge clk);
    #1;

    run(0, 48);

    // asynchronous reset mid-cycle while NMI is granted
    #2 rst = 1'b1;
    #1;
    sb.push_back(22'h0);
    check("async_reset");
    #2 rst = 1'b0;

    run(49, 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jtkcpu_intarb.md
Name: jtkcpu_intarb

Overview:
Interrupt and halt arbiter for the KCPU control unit. Synchronises the external NMI/FIRQ/IRQ/HALT pins, edge-detects NMI, and applies the CC masks. It resolves priority and presents one latched, one-hot request to the microcode sequencer at instruction boundaries. It also sequences the acknowledge handshake, supplying the vector address and the CC mask-set strobes.

Parameters:
NMI_ARM, 1, 1: NMI ignored until armed by first S-register write; 0: NMI armed from reset.

Ports:
clk       in   1   system clock
rst       in   1   asynchronous, active-high reset
cen       in   1   clock enable; all state advances only when cen=1
nmi_n     in   1   NMI pin, active low, falling-edge triggered
firq_n    in   1   FIRQ pin, active low, level
irq_n     in   1   IRQ pin, active low, level
halt_n    in   1   HALT pin, active low, level
cc        in   8   condition codes; bit6=F mask, bit4=I mask
arm_nmi   in   1   pulse: S register written
fetch     in   1   ucode at instruction boundary (also asserted during CWAI/SYNC wait)
int_ack   in   1   ucode finished stacking, vector fetch starting
nmi       out  1   NMI request to ucode
firq      out  1   FIRQ request to ucode
irq       out  1   IRQ request to ucode
int_vec   out  16  vector address: NMI FFFC, FIRQ FFF6, IRQ FFF8, else 0000
set_i     out  1   one-cen strobe: set CC.I
set_f     out  1   one-cen strobe: set CC.F
halted    out  1   CPU held in halt

Behaviour:
- Reset (async): all outputs 0, int_vec=0000. Synchronisers are loaded with 1 (inactive). nmi_pend=0. nmi_armed=~NMI_ARM. State=IDLE.
- Synchronisers: each pin passes through 2 flops clocked on cen. A pin change at cen edge k is usable at edge k+2.
- NMI edge: a synchronised 1->0 transition sets nmi_pend, but only if nmi_armed. Edges before arming are discarded, not deferred. nmi_armed is set by arm_nmi and clears only on reset.
- Candidates:
  - nmi_c = nmi_pend
  - firq_c = ~firq_s & ~cc[6]
  - irq_c = ~irq_s & ~cc[4]
- Priority: NMI > FIRQ > IRQ.
- IDLE:
  - fetch & halt_s active -> HALTED; halted=1 on the same edge. Halt wins over any simultaneous interrupt.
  - Otherwise, fetch & any candidate -> REQ. The winner is latched into exactly one of nmi/firq/irq, and int_vec is set on the same edge.
  - fetch=0: no action; pending NMI is retained.
- REQ:
  - Outputs are held stable even if the source level deasserts or the mask changes (request is committed).
  - A new NMI edge during REQ only sets nmi_pend; the current grant is not pre-empted.
  - int_ack -> SERVICE.
- SERVICE (exactly one cen cycle):
  - set_i=1 for all sources; set_f=1 for NMI and FIRQ.
  - Clears nmi_pend if the grant was NMI. If a fresh edge arrives in the same cycle, pend remains set (set wins).
  - Next: IDLE; request outputs and int_vec return to 0.
- HALTED:
  - halted=1, no requests issued; nmi_pend is still captured.
  - Leaves to IDLE on the first cen edge with halt_s inactive; halted=0 on that edge.
- int_ack outside REQ is ignored. halt during REQ/SERVICE is deferred to the next fetch in IDLE.
- cen=0: no state, synchroniser, or strobe change. Strobes are levels lasting one cen-qualified cycle.

Test Plan:
1. Reset, NMI_ARM=1; pulse nmi_n low before arm_nmi, then fetch=1 -> nmi stays 0. Then arm_nmi, new falling edge, fetch -> nmi=1, int_vec=FFFC.
2. cc=00, firq_n=0 and irq_n=0 simultaneously, fetch=1 -> firq=1, int_vec=FFF6. Then int_ack -> set_i=1, set_f=1 for one cen; next cycle firq=0.
3. cc[4]=1, irq_n=0, fetch=1 -> no request. Clear cc[4] -> irq=1, int_vec=FFF8 at 2 cen after the pin fall plus next fetch. Then int_ack -> set_i=1, set_f=0.
4. irq granted (REQ); release irq_n and set cc[4]=1 -> irq stays 1 until int_ack. Then NMI edge during REQ -> nmi asserted at next fetch after SERVICE.
5. halt_n=0 with irq_n=0, fetch=1 -> halted=1, irq=0. Release halt_n -> halted=0, then irq=1 on next fetch.
6. Assert rst asynchronously while in REQ with nmi=1 -> all outputs 0 immediately, state IDLE, nmi_armed=0. Toggle cen=0 for 5 cycles with pins active -> no output change.
